// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the intersection scheduler.
//   - state_e   : 3-bit phase codes, also driven out on the phase port
//   - LAMP_*    : lamp head encoding shared with the light-head FSM
//   - lamp_of() : Moore lamp decode for one street
package traffic_pkg;

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    RED_A = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    RED_B = 3'd5,
    WALK  = 3'd6,
    RED_W = 3'd7
  } state_e;

  localparam logic [1:0] LAMP_GRN = 2'b00;
  localparam logic [1:0] LAMP_YEL = 2'b01;
  localparam logic [1:0] LAMP_RED = 2'b10;

  // A street is green only in its own green state, yellow only in its own
  // yellow state, and red everywhere else (including all clearance phases).
  function automatic logic [1:0] lamp_of(state_e s, state_e grn, state_e yel);
    if (s == grn) return LAMP_GRN;
    if (s == yel) return LAMP_YEL;
    return LAMP_RED;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: tick-driven dwell counter for the scheduler phases.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   tick         advance the count by one
//   clear        force count to 0 (state change); wins over tick
//   sat_en       hold the count once it reaches sat_lim
//   sat_lim      saturation value
//   done_n       compare value; done = (count == done_n)
//   count        current dwell count
//   done         count equals done_n
module dwell_timer
  import traffic_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clear,
  input  logic             sat_en,
  input  logic [CNT_W-1:0] sat_lim,
  input  logic [CNT_W-1:0] done_n,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick) begin
      if (!(sat_en && (count_q >= sat_lim))) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign done  = (count_q == done_n);

endmodule

// File: rtl/traffic_sched.sv
// traffic_sched: timed, demand-driven scheduler for two crossing streets
// (A, B) plus a shared pedestrian crossing.
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-low reset
//   tick      one-cycle timebase enable; all dwells count ticks
//   TA, TB    traffic present on street A / B
//   ped_req   pedestrian button (level or pulse)
//   LA, LB    lamp heads (00 green, 01 yellow, 10 red)
//   walk      walk signal lit
//   ped_ack   one-cycle pulse on the first cycle of WALK
//   phase     current state code
module traffic_sched
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 3,
  parameter int MAX_GREEN = 6,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 4,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       TA,
  input  logic       TB,
  input  logic       ped_req,
  output logic [1:0] LA,
  output logic [1:0] LB,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  // Dwell limits expressed as the last timer value of each phase.
  localparam logic [CNT_W-1:0] MIN_M1  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_M1  = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_M1 = CNT_W'(WALK_T - 1);

  state_e           state_d, state_q;
  logic             ped_pending_d, ped_pending_q;
  logic             next_b_d, next_b_q;
  logic             ped_ack_d, ped_ack_q;

  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] done_n;
  logic             done;
  logic             is_green;
  logic             min_ok;
  logic             state_chg;
  logic             enter_walk;

  // Compare value for the current phase; greens compare against the
  // max-green point so done doubles as the "green expired" flag.
  always_comb begin
    done_n   = AR_M1;
    is_green = 1'b0;
    case (state_q)
      A_GRN, B_GRN: begin
        done_n   = MAX_M1;
        is_green = 1'b1;
      end
      A_YEL, B_YEL: done_n = YEL_M1;
      WALK:         done_n = WALK_M1;
      default:      done_n = AR_M1;
    endcase
  end

  assign min_ok = (timer >= MIN_M1);

  // Next-state logic; nothing moves unless tick is high.
  always_comb begin
    state_d  = state_q;
    next_b_d = next_b_q;
    if (tick) begin
      case (state_q)
        A_GRN: if (min_ok && (TB || ped_pending_q) && (!TA || done)) state_d = A_YEL;
        A_YEL: if (done) state_d = RED_A;
        RED_A: begin
          if (done) begin
            if (ped_pending_q) begin
              state_d  = WALK;
              next_b_d = 1'b1;
            end else begin
              state_d = B_GRN;
            end
          end
        end
        B_GRN: if (min_ok && (TA || ped_pending_q) && (!TB || done)) state_d = B_YEL;
        B_YEL: if (done) state_d = RED_B;
        RED_B: begin
          if (done) begin
            if (ped_pending_q) begin
              state_d  = WALK;
              next_b_d = 1'b0;
            end else begin
              state_d = A_GRN;
            end
          end
        end
        WALK:  if (done) state_d = RED_W;
        RED_W: if (done) state_d = next_b_q ? B_GRN : A_GRN;
        default: state_d = A_GRN;
      endcase
    end
  end

  assign state_chg  = (state_d != state_q);
  assign enter_walk = (state_d == WALK) && (state_q != WALK);

  // Entry into WALK consumes the request; a press on the same edge as a
  // red-exit decision that does not enter WALK is kept for the next chance.
  always_comb begin
    ped_pending_d = ped_pending_q;
    if (enter_walk) begin
      ped_pending_d = 1'b0;
    end else if (ped_req && (state_q != WALK)) begin
      ped_pending_d = 1'b1;
    end
    ped_ack_d = enter_walk;
  end

  dwell_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .clear   (state_chg),
    .sat_en  (is_green),
    .sat_lim (MAX_M1),
    .done_n  (done_n),
    .count   (timer),
    .done    (done)
  );

  // State and control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= A_GRN;
      ped_pending_q <= 1'b0;
      next_b_q      <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ped_pending_q <= ped_pending_d;
      next_b_q      <= next_b_d;
      ped_ack_q     <= ped_ack_d;
    end
  end

  // Moore output decode
  assign LA      = lamp_of(state_q, A_GRN, A_YEL);
  assign LB      = lamp_of(state_q, B_GRN, B_YEL);
  assign walk    = (state_q == WALK);
  assign ped_ack = ped_ack_q;
  assign phase   = state_q;

endmodule

// File: tb/tb_traffic_sched.sv
module tb_traffic_sched;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       TA;
  logic       TB;
  logic       ped_req;
  logic [1:0] LA;
  logic [1:0] LB;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;

  int n_assert;
  int n_fail;

  localparam logic [2:0] S_AGRN = 3'd0;
  localparam logic [2:0] S_AYEL = 3'd1;
  localparam logic [2:0] S_REDA = 3'd2;
  localparam logic [2:0] S_BGRN = 3'd3;
  localparam logic [2:0] S_BYEL = 3'd4;
  localparam logic [2:0] S_REDB = 3'd5;
  localparam logic [2:0] S_WALK = 3'd6;
  localparam logic [2:0] S_REDW = 3'd7;

  localparam logic [1:0] G = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] R = 2'b10;

  traffic_sched dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .TA      (TA),
    .TB      (TB),
    .ped_req (ped_req),
    .LA      (LA),
    .LB      (LB),
    .walk    (walk),
    .ped_ack (ped_ack),
    .phase   (phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input string field, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] ph, input logic [1:0] la,
                         input logic [1:0] lb, input logic wk, input logic ack);
    chk(tag, "phase",   8'(phase),   8'(ph));
    chk(tag, "LA",      8'(LA),      8'(la));
    chk(tag, "LB",      8'(LB),      8'(lb));
    chk(tag, "walk",    8'(walk),    8'(wk));
    chk(tag, "ped_ack", 8'(ped_ack), 8'(ack));
  endtask

  // Sample n consecutive post-edge cycles, each expected in the same state.
  task automatic expect_for(input string tag, input int n, input logic [2:0] ph, input logic [1:0] la,
                            input logic [1:0] lb, input logic wk, input logic ack);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk_out(tag, ph, la, lb, wk, ack);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out(tag, S_AGRN, G, R, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b0;
    tick     = 1'b1;
    TA       = 1'b1;
    TB       = 1'b0;
    ped_req  = 1'b0;

    // 1. Reset and idle, then saturated timer gives an immediate change
    do_reset("rst1");
    expect_for("idle", 20, S_AGRN, G, R, 1'b0, 1'b0);
    TB = 1'b1;
    expect_for("sat_chg", 1, S_AYEL, Y, R, 1'b0, 1'b0);

    // 2. Change on demand
    TA = 1'b0; TB = 1'b1;
    do_reset("rst2");
    expect_for("dem_agrn", 2, S_AGRN, G, R, 1'b0, 1'b0);
    expect_for("dem_ayel", 2, S_AYEL, Y, R, 1'b0, 1'b0);
    expect_for("dem_reda", 1, S_REDA, R, R, 1'b0, 1'b0);
    expect_for("dem_bgrn", 8, S_BGRN, R, G, 1'b0, 1'b0);

    // 3. Max green with both streets loaded
    TA = 1'b1; TB = 1'b1;
    do_reset("rst3");
    expect_for("max_agrn", 5, S_AGRN, G, R, 1'b0, 1'b0);
    expect_for("max_ayel", 2, S_AYEL, Y, R, 1'b0, 1'b0);
    expect_for("max_reda", 1, S_REDA, R, R, 1'b0, 1'b0);
    expect_for("max_bgrn", 6, S_BGRN, R, G, 1'b0, 1'b0);
    expect_for("max_byel", 2, S_BYEL, R, Y, 1'b0, 1'b0);
    expect_for("max_redb", 1, S_REDB, R, R, 1'b0, 1'b0);
    expect_for("max_agrn2", 1, S_AGRN, G, R, 1'b0, 1'b0);

    // 4. Pedestrian service; presses during WALK are ignored
    TA = 1'b1; TB = 1'b0;
    do_reset("rst4");
    ped_req = 1'b1;
    expect_for("ped_agrn", 1, S_AGRN, G, R, 1'b0, 1'b0);
    ped_req = 1'b0;
    expect_for("ped_agrn", 4, S_AGRN, G, R, 1'b0, 1'b0);
    expect_for("ped_ayel", 2, S_AYEL, Y, R, 1'b0, 1'b0);
    expect_for("ped_reda", 1, S_REDA, R, R, 1'b0, 1'b0);
    expect_for("ped_walk_ack", 1, S_WALK, R, R, 1'b1, 1'b1);
    ped_req = 1'b1;
    expect_for("ped_walk", 3, S_WALK, R, R, 1'b1, 1'b0);
    ped_req = 1'b0;
    expect_for("ped_redw", 1, S_REDW, R, R, 1'b0, 1'b0);
    expect_for("ped_bgrn", 3, S_BGRN, R, G, 1'b0, 1'b0);
    expect_for("ped_byel", 2, S_BYEL, R, Y, 1'b0, 1'b0);
    expect_for("ped_redb", 1, S_REDB, R, R, 1'b0, 1'b0);
    expect_for("ped_agrn2", 2, S_AGRN, G, R, 1'b0, 1'b0);

    // 5a. Tick gating inside A_YEL
    TA = 1'b0; TB = 1'b1;
    do_reset("rst5");
    expect_for("gate_agrn", 2, S_AGRN, G, R, 1'b0, 1'b0);
    expect_for("gate_ayel", 1, S_AYEL, Y, R, 1'b0, 1'b0);
    tick = 1'b0;
    expect_for("gate_hold", 10, S_AYEL, Y, R, 1'b0, 1'b0);
    tick = 1'b1;
    expect_for("gate_ayel2", 1, S_AYEL, Y, R, 1'b0, 1'b0);
    expect_for("gate_reda", 1, S_REDA, R, R, 1'b0, 1'b0);

    // 5b. Asynchronous reset in the middle of WALK
    do_reset("rst6");
    ped_req = 1'b1;
    expect_for("mw_agrn", 1, S_AGRN, G, R, 1'b0, 1'b0);
    ped_req = 1'b0;
    expect_for("mw_agrn", 1, S_AGRN, G, R, 1'b0, 1'b0);
    expect_for("mw_ayel", 2, S_AYEL, Y, R, 1'b0, 1'b0);
    expect_for("mw_reda", 1, S_REDA, R, R, 1'b0, 1'b0);
    expect_for("mw_walk_ack", 1, S_WALK, R, R, 1'b1, 1'b1);
    expect_for("mw_walk", 1, S_WALK, R, R, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    chk_out("mw_async", S_AGRN, G, R, 1'b0, 1'b0);
    TA = 1'b1; TB = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    expect_for("mw_after", 8, S_AGRN, G, R, 1'b0, 1'b0);

    // 5c. Reset discards a pending pedestrian request
    do_reset("rst7");
    ped_req = 1'b1;
    expect_for("pc_agrn", 1, S_AGRN, G, R, 1'b0, 1'b0);
    ped_req = 1'b0;
    do_reset("rst8");
    expect_for("pc_hold", 10, S_AGRN, G, R, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
